// File: rtl/cpu_writeback.sv
// cpu_writeback: retires one instruction per request, updating the Current Result and read-modify-writing Data Memory.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   wb_start                  one-cycle retire request (sampled only in IDLE)
//   instr_code[7:0]           instruction code
//   dm_type[1:0]              00 BIT, 01 BYTE, 10 WORD, 11 DWORD
//   dm_addr[DM_ADDR_W-1:0]    target word address
//   dm_sel[4:0]               lane select within the word
//   alu_out_cr[31:0]          value for the Current Result
//   alu_out_dm[31:0]          value for the selected memory lane
//   dm_rdata[31:0]            memory read data, valid one cycle after dm_re
//   cr_out[31:0]              Current Result register
//   dm_re, dm_raddr           memory read strobe / address
//   dm_we, dm_waddr, dm_wdata memory write strobe / address / merged word
//   wb_busy, wb_done          operation in progress / completion pulse
//
// Build option: WB_DWORD_FAST_EN lets DWORD writes skip the read phase.
module cpu_writeback #(
    parameter int DM_ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_start,
    input  logic [7:0]           instr_code,
    input  logic [1:0]           dm_type,
    input  logic [DM_ADDR_W-1:0] dm_addr,
    input  logic [4:0]           dm_sel,
    input  logic [31:0]          alu_out_cr,
    input  logic [31:0]          alu_out_dm,
    input  logic [31:0]          dm_rdata,
    output logic [31:0]          cr_out,
    output logic                 dm_re,
    output logic                 dm_we,
    output logic [DM_ADDR_W-1:0] dm_raddr,
    output logic [DM_ADDR_W-1:0] dm_waddr,
    output logic [31:0]          dm_wdata,
    output logic                 wb_busy,
    output logic                 wb_done
);
    localparam logic [7:0] LD_I     = 8'h01;
    localparam logic [7:0] LDN_I    = 8'h02;
    localparam logic [7:0] LDI_I    = 8'h03;
    localparam logic [7:0] ST_I     = 8'h04;
    localparam logic [7:0] STN_I    = 8'h05;
    localparam logic [7:0] S_I      = 8'h06;
    localparam logic [7:0] R_I      = 8'h07;
    localparam logic [7:0] AND_I    = 8'h08;
    localparam logic [7:0] ANDN_I   = 8'h09;
    localparam logic [7:0] ANDI_I   = 8'h0A;
    localparam logic [7:0] OR_I     = 8'h0B;
    localparam logic [7:0] ORN_I    = 8'h0C;
    localparam logic [7:0] ORI_I    = 8'h0D;
    localparam logic [7:0] XOR_I    = 8'h0E;
    localparam logic [7:0] XORN_I   = 8'h0F;
    localparam logic [7:0] XORI_I   = 8'h10;
    localparam logic [7:0] NOT_I    = 8'h11;
    localparam logic [7:0] EQU_I    = 8'h12;
    localparam logic [7:0] SR_I     = 8'h13;
    localparam logic [7:0] SL_I     = 8'h14;
    localparam logic [7:0] F_TRIG_I = 8'h15;
    localparam logic [7:0] R_TRIG_I = 8'h16;

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;

    state_t               state, next_state;
    logic [1:0]           l_type;
    logic [DM_ADDR_W-1:0] l_addr;
    logic [4:0]           l_sel;
    logic [31:0]          l_dm;
    logic                 accept, cr_cls, dm_cls, fast;

    // Replace the selected lane of old with the low bits of d.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] typ, input logic [4:0] sel);
        logic [31:0] m;
        logic [4:0]  lo;
        m  = typ == 2'd0 ? 32'h1 : typ == 2'd1 ? 32'hFF : typ == 2'd2 ? 32'hFFFF : 32'hFFFF_FFFF;
        lo = typ == 2'd0 ? sel : typ == 2'd1 ? {sel[1:0], 3'b0} : typ == 2'd2 ? {sel[0], 4'b0} : 5'd0;
        return (old & ~(m << lo)) | ((d & m) << lo);
    endfunction

    assign accept = wb_start && state == IDLE;
    assign cr_cls = instr_code inside {LD_I, LDN_I, LDI_I, SR_I, SL_I, AND_I, ANDN_I, ANDI_I,
                                       OR_I, ORN_I, ORI_I, XOR_I, XORN_I, XORI_I, NOT_I, EQU_I,
                                       F_TRIG_I, R_TRIG_I};
    // S/R only touch memory when the current result (before this instruction) is true.
    assign dm_cls = instr_code inside {ST_I, STN_I, F_TRIG_I, R_TRIG_I} ||
                    (instr_code inside {S_I, R_I} && cr_out[0]);

`ifdef WB_DWORD_FAST_EN
    assign fast = dm_type == 2'b11;
`else
    assign fast = 1'b0;
`endif

    always_comb begin
        next_state = state == IDLE ? (wb_start ? (dm_cls ? (fast ? WR : RD) : DONE) : IDLE) :
                     state == RD   ? WAIT :
                     state == WAIT ? WR :
                     state == WR   ? DONE : IDLE;
        dm_re      = state == RD;
        dm_we      = state == WR;
        wb_busy    = state != IDLE;
        wb_done    = state == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cr_out   <= '0;
            l_type   <= '0;
            l_addr   <= '0;
            l_sel    <= '0;
            l_dm     <= '0;
            dm_raddr <= '0;
            dm_waddr <= '0;
            dm_wdata <= '0;
        end else if (accept) begin
            l_type <= dm_type;
            l_addr <= dm_addr;
            l_sel  <= dm_sel;
            l_dm   <= alu_out_dm;
            if (cr_cls)
                cr_out <= alu_out_cr;
            if (dm_cls && !fast)
                dm_raddr <= dm_addr;
            if (dm_cls && fast) begin
                dm_waddr <= dm_addr;
                dm_wdata <= alu_out_dm;
            end
        end else if (state == WAIT) begin
            dm_waddr <= l_addr;
            dm_wdata <= merge(dm_rdata, l_dm, l_type, l_sel);
        end
    end
endmodule

// File: tb/tb_cpu_writeback.sv
// tb_cpu_writeback: randomized scoreboard bench for cpu_writeback against a lane-level memory model.
module tb_cpu_writeback;
    localparam int AW = 8;
    localparam logic [7:0] LD = 8'h01, LDN = 8'h02, LDI = 8'h03, ST = 8'h04, STN = 8'h05,
                           S = 8'h06, R = 8'h07, ANDC = 8'h08, ANDN = 8'h09, ANDI = 8'h0A,
                           ORC = 8'h0B, ORN = 8'h0C, ORI = 8'h0D, XORC = 8'h0E, XORN = 8'h0F,
                           XORI = 8'h10, NOTC = 8'h11, EQU = 8'h12, SR = 8'h13, SL = 8'h14,
                           FT = 8'h15, RT = 8'h16;

    logic          clk = 0, rst = 0, wb_start = 0;
    logic [7:0]    instr_code = 0;
    logic [1:0]    dm_type = 0;
    logic [AW-1:0] dm_addr = 0;
    logic [4:0]    dm_sel = 0;
    logic [31:0]   alu_out_cr = 0, alu_out_dm = 0, dm_rdata = 0;
    logic [31:0]   cr_out, dm_wdata;
    logic          dm_re, dm_we, wb_busy, wb_done;
    logic [AW-1:0] dm_raddr, dm_waddr;

    cpu_writeback #(.DM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .wb_start(wb_start), .instr_code(instr_code), .dm_type(dm_type),
        .dm_addr(dm_addr), .dm_sel(dm_sel), .alu_out_cr(alu_out_cr), .alu_out_dm(alu_out_dm),
        .dm_rdata(dm_rdata), .cr_out(cr_out), .dm_re(dm_re), .dm_we(dm_we), .dm_raddr(dm_raddr),
        .dm_waddr(dm_waddr), .dm_wdata(dm_wdata), .wb_busy(wb_busy), .wb_done(wb_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] cr; int lat; } done_t;
    typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;

    done_t       dq[$];
    wr_t         wq[$];
    logic [31:0] mem[256];
    logic [31:0] ref_mem[256];
    logic [31:0] cr_m = 0;
    int          cyc = 0, s_cyc = 0, n_vec = 0, n_fail = 0;
    bit          rd_ok = 0;
    logic [7:0]  codes[24] = '{LD, LDN, LDI, ST, STN, S, R, ANDC, ANDN, ANDI, ORC, ORN, ORI, XORC,
                               XORN, XORI, NOTC, EQU, SR, SL, FT, RT, 8'h00, 8'hEE};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory responder: read data appears the cycle after dm_re.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dm_re) dm_rdata <= mem[dm_raddr];
        if (dm_we) mem[dm_waddr] <= dm_wdata;
    end

    // Monitor: pops expectations whenever the DUT writes or completes.
    always @(negedge clk) begin
        if (!rst) begin
            if (dm_re && !rd_ok) chk("stray_read", {31'b0, dm_re}, 0);
            if (dm_we) begin
                if (wq.size() != 0) begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", {24'b0, dm_waddr}, {24'b0, w.a});
                    chk("wr_data", dm_wdata, w.d);
                end else chk("stray_write", {31'b0, dm_we}, 0);
            end
            if (wb_done) begin
                if (dq.size() != 0) begin
                    done_t e;
                    e = dq.pop_front();
                    chk("cr_out", cr_out, e.cr);
                    chk("latency", cyc - s_cyc, e.lat);
                    chk("wq_drained", wq.size(), 0);
                end else chk("stray_done", {31'b0, wb_done}, 0);
            end
        end
    end

    // New word computed bit by bit from the lane position and width.
    function automatic logic [31:0] model_word(input logic [31:0] old, input logic [31:0] d,
                                               input logic [1:0] t, input logic [4:0] s);
        int lo, w;
        logic [31:0] r;
        case (t)
            2'd0: begin lo = s;         w = 1;  end
            2'd1: begin lo = s[1:0] * 8; w = 8;  end
            2'd2: begin lo = s[0] * 16;  w = 16; end
            default: begin lo = 0;      w = 32; end
        endcase
        r = old;
        for (int i = 0; i < w; i++) r[lo + i] = d[i];
        return r;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 20 && wb_busy; i++) @(negedge clk);
        chk("idle_timeout", {31'b0, wb_busy}, 0);
        chk("done_pending", dq.size(), 0);
    endtask

    task automatic issue(input logic [7:0] c, input logic [1:0] t, input logic [AW-1:0] a,
                         input logic [4:0] s, input logic [31:0] vc, input logic [31:0] vd,
                         input bit wait_end);
        bit dmc, fast;
        logic [31:0] nw;
        @(negedge clk);
`ifdef WB_DWORD_FAST_EN
        fast = t == 2'd3;
`else
        fast = 0;
`endif
        dmc = c inside {ST, STN, FT, RT} || (c inside {S, R} && cr_m[0]);
        if (c inside {LD, LDN, LDI, SR, SL, ANDC, ANDN, ANDI, ORC, ORN, ORI, XORC, XORN, XORI,
                      NOTC, EQU, FT, RT}) cr_m = vc;
        if (dmc) begin
            nw = model_word(ref_mem[a], vd, t, s);
            ref_mem[a] = nw;
            wq.push_back('{a, nw});
        end
        dq.push_back('{cr_m, !dmc ? 1 : fast ? 2 : 4});
        rd_ok = dmc && !fast;
        instr_code = c; dm_type = t; dm_addr = a; dm_sel = s; alu_out_cr = vc; alu_out_dm = vd;
        wb_start = 1;
        s_cyc = cyc;
        @(negedge clk);
        wb_start = 0;
        instr_code = codes[$urandom_range(0, 23)]; dm_type = 2'($urandom); dm_addr = AW'($urandom);
        dm_sel = 5'($urandom); alu_out_cr = $urandom; alu_out_dm = $urandom;
        if (wait_end) wait_idle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cr"}, cr_out, 0);
        chk({tag, "_re_we_busy_done"}, {28'b0, dm_re, dm_we, wb_busy, wb_done}, 0);
        chk({tag, "_raddr"}, {24'b0, dm_raddr}, 0);
        chk({tag, "_waddr"}, {24'b0, dm_waddr}, 0);
        chk({tag, "_wdata"}, dm_wdata, 0);
    endtask

    initial begin
        logic [31:0] old;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        #1 rst = 1;
        #1 chk_reset_outputs("reset");
        @(negedge clk) rst = 0;

        mem[8'h10] = 32'hFFFF_FFFF; ref_mem[8'h10] = 32'hFFFF_FFFF;
        issue(ST, 2'd0, 8'h10, 5'd5, 32'h5555_0000, 32'h0, 1);
        chk("bit_clear_mem", mem[8'h10], 32'hFFFF_FFDF);

        mem[8'h20] = 32'h1234_5678; ref_mem[8'h20] = 32'h1234_5678;
        issue(ST, 2'd1, 8'h20, 5'd2, 32'h0, 32'h0000_00AB, 1);
        chk("byte_lane_mem", mem[8'h20], 32'h12AB_5678);

        issue(LD, 2'd0, 8'h00, 5'd0, 32'h0, 32'h0, 1);
        issue(S, 2'd0, 8'h00, 5'd0, 32'h0, 32'h1, 1);
        issue(LD, 2'd0, 8'h00, 5'd0, 32'h1, 32'h0, 1);
        mem[0] = 32'h0; ref_mem[0] = 32'h0;
        issue(S, 2'd0, 8'h00, 5'd0, 32'h1, 32'h1, 1);
        chk("set_bit_mem", mem[0], 32'h1);

        issue(FT, 2'd3, 8'h30, 5'd0, 32'h1, 32'h0, 1);
        chk("dword_mem", mem[8'h30], 32'h0);

        // A start arriving mid-operation must be dropped (LD here would change cr_out).
        issue(ST, 2'd2, 8'h40, 5'd1, 32'h0, 32'hBEEF, 0);
        @(negedge clk);
        instr_code = LD; alu_out_cr = 32'hDEAD_0000; wb_start = 1;
        @(negedge clk);
        wb_start = 0;
        wait_idle();

        // Reset in WAIT aborts the write with no completion.
        old = ref_mem[8'h50];
        issue(ST, 2'd1, 8'h50, 5'd3, 32'h0, 32'h77, 0);
        @(negedge clk);
        rst = 1;
        #1 chk_reset_outputs("abort");
        dq.delete(); wq.delete(); cr_m = 0; rd_ok = 0; ref_mem[8'h50] = old;
        @(negedge clk) rst = 0;
        repeat (3) @(negedge clk);
        chk("abort_no_write", mem[8'h50], old);

        for (int n = 0; n < 200; n++)
            issue(codes[$urandom_range(0, 23)], 2'($urandom), AW'($urandom), 5'($urandom),
                  $urandom, $urandom, 1);
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) chk("final_mem", mem[i], ref_mem[i]);
        chk("final_cr", cr_out, cr_m);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
